// File: rtl/alu_sequencer.sv
// Issue controller between the key-handling FSM and the shared ALU: latches
// operands, waits a fixed settling latency, captures into the accumulator.
module alu_sequencer #(
  parameter int         WIDTH    = 16,
  parameter int         LATENCY  = 4,
  parameter logic [3:0] OP_PLUS  = 4'b1100,
  parameter logic [3:0] OP_MINUS = 4'b1101,
  parameter logic [3:0] OP_MULT  = 4'b1110,
  parameter logic [3:0] OP_DIV   = 4'b1111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             req,
  input  logic [3:0]       reqOp,
  input  logic [WIDTH-1:0] reqNum1,
  input  logic [WIDTH-1:0] reqNum2,
  input  logic             reqUseAcc,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] ALUNum1,
  output logic [WIDTH-1:0] ALUNum2,
  output logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] ALUres,
  input  logic             ALUValid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t     state, next_state;
  logic [3:0] cnt;
  logic       err_q;
  logic       op_legal, div_zero, issue_ok, issue_err;

  // OP_MINUS/OP_MULT sit inside the OP_PLUS..OP_DIV range check
  assign op_legal  = (reqOp >= OP_PLUS) && (reqOp <= OP_DIV);
  assign div_zero  = (reqOp == OP_DIV) && (reqNum2 == '0);
  assign issue_ok  = (state == S_IDLE) && req && op_legal && !div_zero;
  assign issue_err = (state == S_IDLE) && req && !(op_legal && !div_zero);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (req) next_state = issue_ok ? S_WAIT : S_DONE;
      S_WAIT: if (cnt == '0) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (clr) next_state = S_IDLE;
  end

  always_comb begin
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    error = (state == S_DONE) && err_q;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      result  <= '0;
      ALUNum1 <= '0;
      ALUNum2 <= '0;
      ALUOp   <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      if (issue_ok) begin
        ALUNum1 <= reqUseAcc ? result : reqNum1;
        ALUNum2 <= reqNum2;
        ALUOp   <= reqOp;
        cnt     <= LAT_M1;
      end
      if (issue_err) err_q <= 1'b1;
      if (state == S_WAIT) begin
        if (cnt != '0) cnt <= cnt - 4'd1;
        else begin
          err_q <= !ALUValid;
          if (ALUValid) result <= ALUres;
        end
      end
      if (state == S_DONE) err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table for single operations plus
// hand sequences for busy-ignore and clear/abort corner cases.
module tb_alu_sequencer;
  localparam int W = 16;

  logic         clk = 0, rst = 1, clr = 0, req = 0, reqUseAcc = 0;
  logic [3:0]   reqOp = 0;
  logic [W-1:0] reqNum1 = 0, reqNum2 = 0;
  logic         busy, done, error;
  logic [W-1:0] result, ALUNum1, ALUNum2, ALUres;
  logic [3:0]   ALUOp;
  logic         ALUValid;
  logic         alu_ok = 1;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .reqOp(reqOp),
    .reqNum1(reqNum1), .reqNum2(reqNum2), .reqUseAcc(reqUseAcc),
    .busy(busy), .done(done), .error(error), .result(result),
    .ALUNum1(ALUNum1), .ALUNum2(ALUNum2), .ALUOp(ALUOp),
    .ALUres(ALUres), .ALUValid(ALUValid)
  );

  // Behavioural ALU
  always_comb begin
    case (ALUOp)
      4'b1100: ALUres = ALUNum1 + ALUNum2;
      4'b1101: ALUres = ALUNum1 - ALUNum2;
      4'b1110: ALUres = ALUNum1 * ALUNum2;
      4'b1111: ALUres = (ALUNum2 != 0) ? ALUNum1 / ALUNum2 : '0;
      default: ALUres = '0;
    endcase
    ALUValid = alu_ok;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] n1, n2;
    logic         use_acc, ok;
    int           lat;
    logic         err;
    logic [W-1:0] res, a1;
  } vec_t;

  vec_t vt[10];

  task automatic issue(input logic [3:0] op, input logic [W-1:0] n1, n2, input logic ua);
    reqOp = op; reqNum1 = n1; reqNum2 = n2; reqUseAcc = ua; req = 1;
    tick();
    req = 0; reqUseAcc = 0;
  endtask

  initial begin
    int n, dcnt;
    //       op       n1        n2   acc ok lat err res       a1
    vt[0] = '{4'b1100, 16'd1,    16'd1, 0, 1, 5, 0, 16'd2,    16'd1};
    vt[1] = '{4'b1110, 16'd0,    16'd3, 1, 1, 5, 0, 16'd6,    16'd2};
    vt[2] = '{4'b1111, 16'd9,    16'd0, 0, 1, 1, 1, 16'd6,    16'd2};
    vt[3] = '{4'b0101, 16'd7,    16'd7, 0, 1, 1, 1, 16'd6,    16'd2};
    vt[4] = '{4'b1101, 16'd10,   16'd4, 0, 0, 5, 1, 16'd6,    16'd10};
    vt[5] = '{4'b1101, 16'd0,    16'd4, 1, 1, 5, 0, 16'd2,    16'd6};
    vt[6] = '{4'b1111, 16'd100,  16'd7, 0, 1, 5, 0, 16'd14,   16'd100};
    vt[7] = '{4'b1100, 16'hFFFF, 16'd2, 0, 1, 5, 0, 16'd1,    16'hFFFF};
    vt[8] = '{4'b1011, 16'd3,    16'd3, 0, 1, 1, 1, 16'd1,    16'hFFFF};
    vt[9] = '{4'b1100, 16'd50,   16'd0, 1, 1, 5, 0, 16'd1,    16'd1};

    // Reset and idle
    tick(); tick();
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_error", error, 0); chk("rst_result", result, 0);
    chk("rst_alu1", ALUNum1, 0); chk("rst_alu2", ALUNum2, 0);
    chk("rst_aluop", ALUOp, 0);
    rst = 0;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); dcnt += done; end
    chk("idle_no_done", dcnt, 0);

    // Table of single operations
    for (int i = 0; i < 10; i++) begin
      alu_ok = vt[i].ok;
      issue(vt[i].op, vt[i].n1, vt[i].n2, vt[i].use_acc);
      chk($sformatf("v%0d_busy", i), busy, 1);
      chk($sformatf("v%0d_alu1", i), ALUNum1, vt[i].a1);
      n = 1;
      while (!done && n < 20) begin tick(); n++; end
      chk($sformatf("v%0d_lat", i), n, vt[i].lat);
      chk($sformatf("v%0d_err", i), error, vt[i].err);
      chk($sformatf("v%0d_res", i), result, vt[i].res);
      tick();
      chk($sformatf("v%0d_idle", i), busy, 0);
      chk($sformatf("v%0d_err_low", i), error, 0);
      alu_ok = 1;
    end

    // Request during WAIT is ignored
    issue(4'b1100, 16'd3, 16'd4, 0);
    tick();
    issue(4'b1100, 16'd100, 16'd100, 0);
    dcnt = done;
    for (int i = 0; i < 15; i++) begin tick(); dcnt += done; end
    chk("busy_one_done", dcnt, 1);
    chk("busy_result", result, 7);
    chk("busy_alu1", ALUNum1, 3);

    // Clear during WAIT aborts without a done pulse
    issue(4'b1100, 16'd5, 16'd5, 0);
    tick();
    clr = 1; tick(); clr = 0;
    chk("clr_busy", busy, 0);
    chk("clr_result", result, 0);
    chk("clr_alu1", ALUNum1, 0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); dcnt += done; end
    chk("clr_no_done", dcnt, 0);

    // Clear and request at the same edge: clear wins
    clr = 1;
    issue(4'b1100, 16'd8, 16'd8, 0);
    clr = 0;
    chk("clrreq_busy", busy, 0);
    chk("clrreq_alu1", ALUNum1, 0);
    chk("clrreq_aluop", ALUOp, 0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin tick(); dcnt += done; end
    chk("clrreq_no_done", dcnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue controller between the calculator's main key-handling FSM and the shared ALU. It accepts one operation request at a time, drives the ALU operand/opcode ports, waits a fixed settling latency, and captures the result into an accumulator register. It also returns a one-cycle completion pulse with an error flag. The accumulator can be fed back as the first operand, so chained entries (1 + 1 + 1 =) need no re-entry of the running total.

## Interface
- WIDTH, 16, operand/result width
- LATENCY, 4, ALU settling cycles between issue and capture (legal range 1..15)
- OP_PLUS, 4'b1100, addition opcode
- OP_MINUS, 4'b1101, subtraction opcode
- OP_MULT, 4'b1110, multiplication opcode
- OP_DIV, 4'b1111, division opcode

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- clr  in  1  synchronous clear/abort (AC key)
- req  in  1  request strobe, sampled only in IDLE
- reqOp  in  4  requested opcode
- reqNum1  in  WIDTH  first operand
- reqNum2  in  WIDTH  second operand
- reqUseAcc  in  1  1: use accumulator as first operand instead of reqNum1
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  error status, valid only while done=1, 0 otherwise
- result  out  WIDTH  accumulator (last good result)
- ALUNum1  out  WIDTH  ALU operand 1
- ALUNum2  out  WIDTH  ALU operand 2
- ALUOp  out  4  ALU opcode
- ALUres  in  WIDTH  ALU result
- ALUValid  in  1  ALU result-valid flag

## Operation
- States: IDLE, WAIT, DONE.
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - busy, done, error, result, ALUNum1, ALUNum2 and ALUOp all go to 0.
  - The latency counter goes to 0.
- IDLE, req=1, legal opcode (OP_PLUS..OP_DIV):
  - Latch ALUNum1 = reqUseAcc ? result : reqNum1; ALUNum2 = reqNum2; ALUOp = reqOp.
  - Counter = LATENCY-1; go to WAIT.
- IDLE, req=1, illegal opcode (4'b0000..4'b1011):
  - No ALU update; go to DONE with error=1; result unchanged.
- IDLE, req=1, reqOp=OP_DIV with reqNum2=0:
  - Treated as an error; no ALU update; go to DONE with error=1.
- WAIT:
  - Counter != 0: decrement.
  - Counter == 0: sample ALUres and ALUValid, then go to DONE.
    - ALUValid=1: result = ALUres, error=0.
    - ALUValid=0: result unchanged, error=1.
- DONE:
  - done=1 for exactly this cycle, then go to IDLE.
  - error falls to 0 on leaving DONE.
- req while busy is ignored, not queued; the requester retries after busy falls.
- ALU ports hold their last issued values in every state; they change only on a legal accept, rst or clr.
- clr=1 at any edge, any state:
  - State goes to IDLE; result, ALU ports and counter go to 0.
  - No done pulse is produced; an in-flight operation is discarded.
- Priority at one edge: rst > clr > req.
- Arithmetic is entirely in the ALU. The sequencer does no width extension or truncation: result is a straight WIDTH-bit copy.

## Timing
- Legal request accepted at edge k:
  - ALU ports show new values from cycle k+1; busy=1 from cycle k+1.
  - Capture happens at edge k+LATENCY.
  - done=1 and updated result during cycle k+LATENCY+1.
  - busy=0 and a new request acceptable at edge k+LATENCY+2.
- Illegal opcode or divide-by-zero accepted at edge k: done=1 and error=1 in cycle k+1; IDLE from edge k+2.
- LATENCY=1: WAIT lasts one cycle (capture at edge k+1).
- Throughput: one operation per LATENCY+2 cycles when req is held high continuously.
- result changes only at a capture edge, rst or clr, so it is stable for the display between operations.

## Test plan
- Reset then idle:
  - Stimulus: assert rst 2 cycles.
  - Required: all outputs 0, busy=0; req=0 for 10 cycles produces no done.
- Simple add:
  - Stimulus: reqNum1=1, reqNum2=1, reqOp=4'b1100, req pulse at edge k; ALU model returns 2 with ALUValid=1.
  - Required: done only in cycle k+5 (LATENCY=4), result=16'd2, error=0, busy high over cycles k+1..k+5.
- Chained entry:
  - Stimulus: after the add, reqUseAcc=1, reqNum2=3, reqOp=OP_MULT.
  - Required: ALUNum1=16'd2 at issue; result=16'd6 after done.
- Errors:
  - OP_DIV with reqNum2=0 gives done+error=1 one cycle after accept, result unchanged.
  - reqOp=4'b0101 gives the same response.
  - ALUValid=0 at capture gives error=1, result unchanged.
- Busy and abort:
  - A second req during WAIT is ignored (exactly one done).
  - clr in WAIT: no done, result=0, busy=0 next cycle.
  - clr and req at the same edge: clr wins, nothing is issued.
